// File: rtl/pipe_datapath.sv
// rtl/pipe_datapath.sv - pipelined ARM-style datapath: ID/EX/MEM/WB with forwarding, load-use stall and flags
// Decode delivers pre-muxed register indices; data memory is external and answers within the MEM cycle.
module pipe_datapath #(
    parameter int WIDTH    = 64,
    parameter int NREGS    = 32,
    parameter int ZERO_REG = 31,
    localparam int RA_W    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [RA_W-1:0]  in_ra,
    input  logic [RA_W-1:0]  in_rb,
    input  logic             in_rb_en,
    input  logic [RA_W-1:0]  in_rd,
    input  logic [WIDTH-1:0] in_imm,
    input  logic [WIDTH-1:0] in_link_data,
    input  logic             in_alu_src,
    input  logic [2:0]       in_alu_op,
    input  logic             in_reg_write,
    input  logic             in_mem_read,
    input  logic             in_mem_write,
    input  logic             in_link,
    input  logic             in_set_flags,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic             mem_we,
    output logic             mem_re,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic             flag_neg,
    output logic             flag_zero,
    output logic             flag_overf,
    output logic             flag_cout,
    output logic             ex_zero,
    output logic             wb_valid,
    output logic [RA_W-1:0]  wb_rd,
    output logic [WIDTH-1:0] wb_data
);

    localparam logic [RA_W-1:0] ZR      = RA_W'(ZERO_REG);
    localparam logic [2:0]      OP_PASS = 3'b000;
    localparam logic [2:0]      OP_ADD  = 3'b010;
    localparam logic [2:0]      OP_SUB  = 3'b011;
    localparam logic [2:0]      OP_AND  = 3'b100;
    localparam logic [2:0]      OP_OR   = 3'b101;
    localparam logic [2:0]      OP_XOR  = 3'b110;

    logic [WIDTH-1:0] rf [NREGS];

    logic             idex_valid, idex_alu_src, idex_reg_write, idex_mem_read;
    logic             idex_mem_write, idex_link, idex_set_flags;
    logic [2:0]       idex_alu_op;
    logic [RA_W-1:0]  idex_ra, idex_rb, idex_rd;
    logic [WIDTH-1:0] idex_a, idex_b, idex_imm, idex_link_data;

    logic             exmem_valid, exmem_reg_write, exmem_mem_read, exmem_mem_write, exmem_link;
    logic [RA_W-1:0]  exmem_rd;
    logic [WIDTH-1:0] exmem_alu, exmem_fwd, exmem_wdata;

    logic             memwb_valid, memwb_reg_write;
    logic [RA_W-1:0]  memwb_rd;
    logic [WIDTH-1:0] memwb_data;

    logic             load_use, accept, exmem_fwd_ok;
    logic [WIDTH-1:0] id_a, id_b, fwd_a, fwd_b, b_eff, b_add, alu_r;
    logic [WIDTH:0]   sum;
    logic             alu_c, alu_v;

    assign load_use = idex_valid && idex_mem_read && idex_reg_write && idex_rd != ZR &&
                      (idex_rd == in_ra || (in_rb_en && idex_rd == in_rb));
    assign in_ready = !load_use;
    assign accept   = in_valid && in_ready;

    assign wb_valid = memwb_valid && memwb_reg_write && memwb_rd != ZR;
    assign wb_rd    = memwb_rd;
    assign wb_data  = memwb_data;

    // ID read sees a same-cycle write-back so the register file needs no extra forward path
    always_comb begin
        id_a = rf[in_ra];
        id_b = rf[in_rb];
        if (wb_valid && wb_rd == in_ra) id_a = wb_data;
        if (wb_valid && wb_rd == in_rb) id_b = wb_data;
        if (in_ra == ZR) id_a = '0;
        if (in_rb == ZR) id_b = '0;
    end

    // A load still in MEM cannot forward; the load-use stall guarantees it is in WB by then
    assign exmem_fwd_ok = exmem_valid && exmem_reg_write && !exmem_mem_read && exmem_rd != ZR;

    always_comb begin
        fwd_a = idex_a;
        fwd_b = idex_b;
        if (exmem_fwd_ok && exmem_rd == idex_ra)  fwd_a = exmem_fwd;
        else if (wb_valid && wb_rd == idex_ra)    fwd_a = wb_data;
        if (exmem_fwd_ok && exmem_rd == idex_rb)  fwd_b = exmem_fwd;
        else if (wb_valid && wb_rd == idex_rb)    fwd_b = wb_data;
    end

    always_comb begin
        b_eff = idex_alu_src ? idex_imm : fwd_b;
        b_add = (idex_alu_op == OP_SUB) ? ~b_eff : b_eff;
        sum   = {1'b0, fwd_a} + {1'b0, b_add} + {{WIDTH{1'b0}}, idex_alu_op == OP_SUB};
        alu_r = '0;
        alu_c = 1'b0;
        alu_v = 1'b0;
        case (idex_alu_op)
            OP_PASS: alu_r = b_eff;
            OP_ADD, OP_SUB: begin
                alu_r = sum[WIDTH-1:0];
                alu_c = sum[WIDTH];
                alu_v = (fwd_a[WIDTH-1] == b_add[WIDTH-1]) && (sum[WIDTH-1] != fwd_a[WIDTH-1]);
            end
            OP_AND:  alu_r = fwd_a & b_eff;
            OP_OR:   alu_r = fwd_a | b_eff;
            OP_XOR:  alu_r = fwd_a ^ b_eff;
            default: alu_r = '0;
        endcase
    end

    assign ex_zero   = (alu_r == '0);
    assign mem_addr  = exmem_alu;
    assign mem_wdata = exmem_wdata;
    assign mem_we    = exmem_valid && exmem_mem_write;
    assign mem_re    = exmem_valid && exmem_mem_read;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idex_valid     <= 1'b0;
            idex_alu_src   <= 1'b0;
            idex_reg_write <= 1'b0;
            idex_mem_read  <= 1'b0;
            idex_mem_write <= 1'b0;
            idex_link      <= 1'b0;
            idex_set_flags <= 1'b0;
            idex_alu_op    <= OP_PASS;
            idex_ra        <= '0;
            idex_rb        <= '0;
            idex_rd        <= '0;
            idex_a         <= '0;
            idex_b         <= '0;
            idex_imm       <= '0;
            idex_link_data <= '0;
        end else begin
            idex_valid     <= accept;
            idex_alu_src   <= in_alu_src;
            idex_reg_write <= in_reg_write;
            idex_mem_read  <= in_mem_read;
            idex_mem_write <= in_mem_write;
            idex_link      <= in_link;
            idex_set_flags <= in_set_flags;
            idex_alu_op    <= in_alu_op;
            idex_ra        <= in_ra;
            idex_rb        <= in_rb;
            idex_rd        <= in_rd;
            idex_a         <= id_a;
            idex_b         <= id_b;
            idex_imm       <= in_imm;
            idex_link_data <= in_link_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flag_neg   <= 1'b0;
            flag_zero  <= 1'b0;
            flag_overf <= 1'b0;
            flag_cout  <= 1'b0;
        end else if (idex_valid && idex_set_flags) begin
            flag_neg   <= alu_r[WIDTH-1];
            flag_zero  <= ex_zero;
            flag_overf <= alu_v;
            flag_cout  <= alu_c;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            exmem_valid     <= 1'b0;
            exmem_reg_write <= 1'b0;
            exmem_mem_read  <= 1'b0;
            exmem_mem_write <= 1'b0;
            exmem_link      <= 1'b0;
            exmem_rd        <= '0;
            exmem_alu       <= '0;
            exmem_fwd       <= '0;
            exmem_wdata     <= '0;
            memwb_valid     <= 1'b0;
            memwb_reg_write <= 1'b0;
            memwb_rd        <= '0;
            memwb_data      <= '0;
        end else begin
            exmem_valid     <= idex_valid;
            exmem_reg_write <= idex_reg_write;
            exmem_mem_read  <= idex_mem_read;
            exmem_mem_write <= idex_mem_write;
            exmem_link      <= idex_link;
            exmem_rd        <= idex_rd;
            exmem_alu       <= alu_r;
            exmem_fwd       <= idex_link ? idex_link_data : alu_r;
            exmem_wdata     <= fwd_b;
            memwb_valid     <= exmem_valid;
            memwb_reg_write <= exmem_reg_write;
            memwb_rd        <= exmem_rd;
            memwb_data      <= (exmem_mem_read && !exmem_link) ? mem_rdata : exmem_fwd;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) rf[i] <= '0;
        end else if (wb_valid) begin
            rf[wb_rd] <= wb_data;
        end
    end

endmodule

// File: doc/pipe_datapath.md
Name: pipe_datapath

Overview:
- Parametrised, pipelined successor to the single-cycle ARM datapath.
- Takes pre-decoded instructions from the decode stage over a valid/ready handshake and runs four internal stages: operand read (ID), ALU (EX), data memory (MEM), register write-back (WB).
- Contains its own register file, full forwarding, load-use stall and architectural flag register.
- Data memory is external: the block drives the address/control and receives read data in the same MEM cycle.

Parameters:
WIDTH, 64, datapath and register width in bits
NREGS, 32, number of architectural registers (power of two)
ZERO_REG, 31, index that reads as 0 and ignores writes (XZR)
RA_W, $clog2(NREGS), register-address width (derived, not overridden)

Ports:
clk  in  1  system clock, all state updates on posedge
reset  in  1  asynchronous, active-low reset
in_valid  in  1  decoded instruction present
in_ready  out  1  block accepts instruction this cycle
in_ra  in  RA_W  operand A register (Rn)
in_rb  in  RA_W  operand B / store-data register (already Reg2Loc-muxed)
in_rb_en  in  1  in_rb is read by this instruction
in_rd  in  RA_W  destination register (already Rd/X30-muxed)
in_imm  in  WIDTH  sign-extended immediate (DAddr9 or ALUImm12)
in_link_data  in  WIDTH  PC+4 for BL
in_alu_src  in  1  0: B=reg[rb], 1: B=in_imm
in_alu_op  in  3  000 pass B, 010 add, 011 sub, 100 and, 101 or, 110 xor
in_reg_write  in  1  write rd in WB
in_mem_read  in  1  load; WB data from memory
in_mem_write  in  1  store reg[rb] to ALU address
in_link  in  1  WB data = in_link_data (overrides ALU/memory)
in_set_flags  in  1  update flag register from EX result
mem_addr  out  WIDTH  MEM-stage ALU result
mem_wdata  out  WIDTH  MEM-stage store data
mem_we  out  1  store in MEM stage
mem_re  out  1  load in MEM stage
mem_rdata  in  WIDTH  load data, valid combinationally while mem_re=1
flag_neg, flag_zero, flag_overf, flag_cout  out  1 each  architectural flags
ex_zero  out  1  combinational zero of the current EX result (CBZ resolution)
wb_valid  out  1  WB stage holds a register-writing instruction
wb_rd  out  RA_W  WB destination
wb_data  out  WIDTH  WB write data

Behaviour:
- Reset (reset=0, asynchronous):
  - all stage valids 0; register file all 0; flags 0
  - mem_we=0, mem_re=0, wb_valid=0, in_ready=1
  - reset asserted mid-operation discards all in-flight instructions with no write-back.
- Accept: an instruction enters ID when in_valid && in_ready. Register operands are read combinationally and resolved in the same cycle.
- Timing for an instruction accepted at edge N:
  - EX during cycle N+1; flags visible after edge N+2.
  - MEM during cycle N+2.
  - WB during cycle N+3; register file written at edge N+4.
  - Throughput: 1 instruction per cycle absent stalls.
- Operand resolution, priority high to low:
  - EX/MEM result, if that stage is valid, reg_write, not mem_read, and rd matches
  - MEM/WB write data, if matching
  - register file contents
- Register ZERO_REG:
  - always reads 0; never forwarded
  - writes to it are dropped and wb_valid stays 0.
- Load-use stall:
  - Condition: the ID/EX stage holds a valid mem_read && reg_write with rd==in_ra, or with rd==in_rb while in_rb_en=1, rd≠ZERO_REG.
  - Effect: in_ready=0, a bubble is inserted into EX, and the ID request is held. One stall cycle, after which the MEM/WB forward supplies the data.
  - in_ready depends only on the stall condition, never on in_valid.
- ALU arithmetic, WIDTH bits:
  - add: A+B
  - sub: A+~B+1
  - cout = carry out of the MSB
  - overf = (A[MSB]==B'[MSB]) && (R[MSB]≠A[MSB]), where B' is the effective addend
  - logic and pass ops: cout=0, overf=0
  - neg = R[MSB]; zero = (R==0)
- Flags update only for valid EX instructions with set_flags. Bubbles never change flags.
- WB data select: link ? link_data : (mem_read ? loaded data : ALU result). Load data is captured into MEM/WB at the end of MEM.
- A store uses forwarded reg[rb] as mem_wdata. mem_we/mem_re are asserted only while MEM is valid.
- Simultaneous events:
  - WB writing register r while ID reads r: ID gets the new value.
  - EX and WB both targeting r: EX wins.

Test Plan:
- Reset then load registers: ADDI-style x1=5, x2=7 (alu_src=1, op=add, ra=ZERO_REG), then ADD x3=x1+x2 back-to-back → wb_data=12 at wb_rd=3, no stall; every input drives in_ready=1.
- Flags: SUBS x4 = 0x0 − 0x1 with set_flags → neg=1, zero=0, cout=0, overf=0. ADDS of 0x7FFF…F+1 → overf=1, neg=1.
- Load-use: store x2 (7) to address 16, load x5 from [16], immediately ADD x6=x5+x1 → in_ready=0 for exactly one cycle, mem_we at addr 16 with data 7, x6=12.
- ZERO_REG: write 0x55 to rd=31, then read ra=31 → wb_valid=0 for the write; the consumer sees 0.
- Link: in_link=1, in_link_data=0x1004, rd=30 → x30=0x1004 while the ALU result is ignored.
- Reset asserted mid-stream with three instructions in flight → no subsequent wb_valid, flags 0, register file 0.
